priority_encoder_4to2: RTL and testbench



---
 rtl/priority_encoder_4to2_pkg.sv | 7 +
 rtl/priority_encoder_4to2_prio_enc_comb.sv | 36 +++
 rtl/priority_encoder_4to2.sv | 59 +++++
 tb/tb_priority_encoder_4to2.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/priority_encoder_4to2_pkg.sv
// Shared widths and index type for priority encoders and arbiters built on them.
package priority_encoder_4to2_pkg;
  localparam int IDX_W = 2;
  localparam int N_REQ = 4;

  typedef logic [IDX_W-1:0] idx_t;
endpackage

// File: rtl/priority_encoder_4to2_prio_enc_comb.sv
// Combinational 4-request priority reduction: winner index, any-active, multi-active.
module prio_enc_comb
  import priority_encoder_4to2_pkg::*;
#(
  parameter int HIGH_WINS = 1
) (
  input  logic [N_REQ-1:0] req_i,
  output idx_t             idx_o,
  output logic             valid_o,
  output logic             multi_o
);

  logic [2:0] cnt;

  // Scan order makes the last hit the winner, so the direction sets priority.
  always_comb begin
    idx_o = '0;
    if (HIGH_WINS != 0) begin
      for (int i = 0; i < N_REQ; i++)
        if (req_i[i]) idx_o = idx_t'(i);
    end else begin
      for (int i = N_REQ - 1; i >= 0; i--)
        if (req_i[i]) idx_o = idx_t'(i);
    end
  end

  always_comb begin
    cnt = '0;
    for (int i = 0; i < N_REQ; i++)
      cnt = cnt + {2'b00, req_i[i]};
  end

  assign valid_o = |req_i;
  assign multi_o = (cnt >= 3'd2);

endmodule

// File: rtl/priority_encoder_4to2.sv
// Registered 4-to-2 priority encoder with valid and multi-hot flags; one cycle latency.
module priority_encoder_4to2
  import priority_encoder_4to2_pkg::*;
#(
  parameter int HIGH_WINS = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic d0,
  input  logic d1,
  input  logic d2,
  input  logic d3,
  output logic o0,
  output logic o1,
  output logic valid,
  output logic multi
);

  idx_t idx_c, idx_d, idx_q;
  logic valid_c, valid_d, valid_q;
  logic multi_c, multi_d, multi_q;

  prio_enc_comb #(.HIGH_WINS(HIGH_WINS)) u_enc (
    .req_i   ({d3, d2, d1, d0}),
    .idx_o   (idx_c),
    .valid_o (valid_c),
    .multi_o (multi_c)
  );

  always_comb begin
    idx_d   = idx_q;
    valid_d = valid_q;
    multi_d = multi_q;
    if (en) begin
      idx_d   = idx_c;
      valid_d = valid_c;
      multi_d = multi_c;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q   <= '0;
      valid_q <= 1'b0;
      multi_q <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      valid_q <= valid_d;
      multi_q <= multi_d;
    end
  end

  assign o0    = idx_q[0];
  assign o1    = idx_q[1];
  assign valid = valid_q;
  assign multi = multi_q;

endmodule

// File: tb/tb_priority_encoder_4to2.sv
// Bench for both priority directions: vector table, directed corner sequences, random vs model.
module tb_priority_encoder_4to2;

  logic clk = 1'b0;
  logic rst, en, d0, d1, d2, d3;
  logic ho0, ho1, hvalid, hmulti;
  logic lo0, lo1, lvalid, lmulti;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  priority_encoder_4to2 #(.HIGH_WINS(1)) u_hi (
    .clk(clk), .rst(rst), .en(en), .d0(d0), .d1(d1), .d2(d2), .d3(d3),
    .o0(ho0), .o1(ho1), .valid(hvalid), .multi(hmulti)
  );

  priority_encoder_4to2 #(.HIGH_WINS(0)) u_lo (
    .clk(clk), .rst(rst), .en(en), .d0(d0), .d1(d1), .d2(d2), .d3(d3),
    .o0(lo0), .o1(lo1), .valid(lvalid), .multi(lmulti)
  );

  // Vector: d = {d3,d2,d1,d0}; expected winner for each direction plus flags.
  typedef struct {
    logic [3:0] d;
    logic [1:0] hi;
    logic [1:0] lo;
    logic       v;
    logic       m;
  } vec_t;

  vec_t tbl [16];

  // Reference: packed {idx[1:0], valid, multi} from bit arithmetic on the request value.
  function automatic logic [3:0] ref_out(input int v, input bit high);
    int idx;
    if (v == 0) return 4'b0000;
    if (high) idx = $clog2(v + 1) - 1;
    else      idx = $clog2(v & -v);
    return {2'(idx), 1'b1, ($countones(4'(v)) >= 2)};
  endfunction

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got idx/v/m=%b/%b/%b expected %b/%b/%b",
                  name, act[3:2], act[1], act[0], exp[3:2], exp[1], exp[0]);
  endtask

  function automatic logic [3:0] hi_out();
    return {ho1, ho0, hvalid, hmulti};
  endfunction

  function automatic logic [3:0] lo_out();
    return {lo1, lo0, lvalid, lmulti};
  endfunction

  task automatic set_d(input logic [3:0] v);
    {d3, d2, d1, d0} = v;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] mh, ml, v;
    logic       r, e;

    tbl[0]  = '{4'h0, 2'd0, 2'd0, 1'b0, 1'b0};
    tbl[1]  = '{4'h1, 2'd0, 2'd0, 1'b1, 1'b0};
    tbl[2]  = '{4'h2, 2'd1, 2'd1, 1'b1, 1'b0};
    tbl[3]  = '{4'h3, 2'd1, 2'd0, 1'b1, 1'b1};
    tbl[4]  = '{4'h4, 2'd2, 2'd2, 1'b1, 1'b0};
    tbl[5]  = '{4'h5, 2'd2, 2'd0, 1'b1, 1'b1};
    tbl[6]  = '{4'h6, 2'd2, 2'd1, 1'b1, 1'b1};
    tbl[7]  = '{4'h7, 2'd2, 2'd0, 1'b1, 1'b1};
    tbl[8]  = '{4'h8, 2'd3, 2'd3, 1'b1, 1'b0};
    tbl[9]  = '{4'h9, 2'd3, 2'd0, 1'b1, 1'b1};
    tbl[10] = '{4'hA, 2'd3, 2'd1, 1'b1, 1'b1};
    tbl[11] = '{4'hB, 2'd3, 2'd0, 1'b1, 1'b1};
    tbl[12] = '{4'hC, 2'd3, 2'd2, 1'b1, 1'b1};
    tbl[13] = '{4'hD, 2'd3, 2'd0, 1'b1, 1'b1};
    tbl[14] = '{4'hE, 2'd3, 2'd1, 1'b1, 1'b1};
    tbl[15] = '{4'hF, 2'd3, 2'd0, 1'b1, 1'b1};

    // Reset held two cycles with all requests high.
    rst = 1'b1; en = 1'b1; set_d(4'hF);
    tick(); tick();
    check("reset_hi", hi_out(), 4'b0000);
    check("reset_lo", lo_out(), 4'b0000);
    rst = 1'b0;
    tick();
    check("post_reset_hi", hi_out(), 4'b1111);
    check("post_reset_lo", lo_out(), 4'b0011);

    // Exhaustive table sweep, one vector per cycle.
    for (int i = 0; i < 16; i++) begin
      set_d(tbl[i].d);
      tick();
      check($sformatf("tbl_hi_%0d", i), hi_out(), {tbl[i].hi, tbl[i].v, tbl[i].m});
      check($sformatf("tbl_lo_%0d", i), lo_out(), {tbl[i].lo, tbl[i].v, tbl[i].m});
    end

    // Enable hold: capture d1 only, then freeze while inputs change.
    set_d(4'b0010); tick();
    check("hold_cap_hi", hi_out(), 4'b0110);
    en = 1'b0; set_d(4'b1000);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("hold_%0d_hi", i), hi_out(), 4'b0110);
      check($sformatf("hold_%0d_lo", i), lo_out(), 4'b0110);
    end
    en = 1'b1; tick();
    check("hold_release_hi", hi_out(), 4'b1110);
    check("hold_release_lo", lo_out(), 4'b1110);

    // Reset wins over a deasserted enable.
    set_d(4'hF); tick();
    check("pre_rst_hi", hi_out(), 4'b1111);
    rst = 1'b1; en = 1'b0; tick();
    check("rst_prec_hi", hi_out(), 4'b0000);
    check("rst_prec_lo", lo_out(), 4'b0000);
    rst = 1'b0; en = 1'b1;

    // Latency: a one-cycle d2 pulse shows up exactly one edge later for one cycle.
    set_d(4'h0); tick();
    check("lat_idle", hi_out(), 4'b0000);
    set_d(4'b0100);
    #2;
    check("lat_no_comb_path", hi_out(), 4'b0000);
    tick();
    set_d(4'h0);
    check("lat_pulse_hi", hi_out(), 4'b1010);
    check("lat_pulse_lo", lo_out(), 4'b1010);
    tick();
    check("lat_pulse_gone", hi_out(), 4'b0000);

    // Random traffic against the model, including sporadic reset and enable gaps.
    mh = hi_out() === 4'b0000 ? 4'b0000 : 4'bxxxx;
    ml = 4'b0000;
    for (int i = 0; i < 300; i++) begin
      v = 4'($urandom_range(0, 15));
      r = ($urandom_range(0, 15) == 0);
      e = ($urandom_range(0, 3) != 0);
      rst = r; en = e; set_d(v);
      tick();
      if (r) begin
        mh = 4'b0000; ml = 4'b0000;
      end else if (e) begin
        mh = ref_out(int'(v), 1'b1);
        ml = ref_out(int'(v), 1'b0);
      end
      check($sformatf("rand_%0d_hi", i), hi_out(), mh);
      check($sformatf("rand_%0d_lo", i), lo_out(), ml);
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
